// File: rtl/truth_table_probe_pkg.sv
// Shared types and constants for the 3-input truth-table probe.
package truth_table_pkg;
  localparam int N_INPUTS = 3;
  localparam int N_ROWS   = 8;
  localparam int CODE_W   = 8;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  // Row 000 lands in the MSB so the code reads like the gate's hex name.
  function automatic logic [2:0] row_to_bit(input logic [2:0] k);
    return 3'(N_ROWS - 1) - k;
  endfunction
endpackage

// File: rtl/truth_table_probe_if.sv
// Probe bus: run handshake, assembled code and gate-under-test pins.
// Optional expect-check signals appear when TRUTH_TABLE_EXPECT_CHECK_EN is defined.
interface truth_table_probe_if;
  import truth_table_pkg::*;
  logic                start;
  logic                busy;
  logic                done;
  logic [CODE_W-1:0]   code;
  logic [N_INPUTS-1:0] stim;
  logic                dut_out;
`ifdef TRUTH_TABLE_EXPECT_CHECK_EN
  logic [CODE_W-1:0]   expected;
  logic [CODE_W-1:0]   mismatch;
  logic                match;

  modport master(output start, dut_out, expected,
                 input  busy, done, code, stim, mismatch, match);
  modport slave (input  start, dut_out, expected,
                 output busy, done, code, stim, mismatch, match);
`else
  modport master(output start, dut_out,
                 input  busy, done, code, stim);
  modport slave (input  start, dut_out,
                 output busy, done, code, stim);
`endif
endinterface

// File: rtl/truth_table_probe_sync_ff.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[SYNC_STAGES-2:0], d};
  end

  assign q = sr[SYNC_STAGES-1];
endmodule

// File: rtl/truth_table_probe.sv
// Walks all 8 input rows through a gate, samples its synchronized output, builds the code.
// Define TRUTH_TABLE_EXPECT_CHECK_EN to add expected/mismatch/match comparison.
module truth_table_probe
  import truth_table_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input logic                clk,
  input logic                rst_n,
  truth_table_probe_if.slave bus
);
  if (SETTLE_CYCLES < 2) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 2");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > SETTLE_CYCLES) begin : g_bad_sync
    $error("SYNC_STAGES must be in [2, SETTLE_CYCLES]");
  end

  localparam int CNT_W = $clog2(SETTLE_CYCLES);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          row;
  logic [N_INPUTS-1:0] stim_q;
  logic [CODE_W-1:0]   code_q, code_nxt;
  logic                out_s;
  logic                accept, last_row;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.dut_out),
    .q    (out_s)
  );

  assign accept   = (state == IDLE) && bus.start;
  assign last_row = (row == 3'(N_ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SETTLE;
      SETTLE:  if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_row ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    code_nxt = code_q;
    if (accept)               code_nxt = '0;
    else if (state == SAMPLE) code_nxt[row_to_bit(row)] = out_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      row    <= '0;
      stim_q <= '0;
      code_q <= '0;
    end else begin
      code_q <= code_nxt;
      case (state)
        IDLE: if (bus.start) begin
          cnt    <= '0;
          row    <= '0;
          stim_q <= '0;
        end
        SETTLE: cnt <= cnt + 1'b1;
        SAMPLE: if (!last_row) begin
          row    <= row + 3'd1;
          stim_q <= row + 3'd1;
          cnt    <= '0;
        end
        DONE:    stim_q <= '0;
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.code = code_q;
  assign bus.stim = stim_q;

`ifdef TRUTH_TABLE_EXPECT_CHECK_EN
  logic [CODE_W-1:0] exp_q, mism_q;
  logic              match_q;

  // Compare against code_nxt so the verdict is ready in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q   <= '0;
      mism_q  <= '0;
      match_q <= 1'b0;
    end else if (accept) begin
      exp_q   <= bus.expected;
      mism_q  <= '0;
      match_q <= 1'b0;
    end else if (state == SAMPLE && last_row) begin
      mism_q  <= code_nxt ^ exp_q;
      match_q <= (code_nxt == exp_q);
    end
  end

  assign bus.mismatch = mism_q;
  assign bus.match    = match_q;
`endif
endmodule

// File: tb/tb_truth_table_probe.sv
// Bench for truth_table_probe: behavioural gates on stim, run-level timing/code checks.
module tb_truth_table_probe;
  import truth_table_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  truth_table_probe_if bus();

  truth_table_probe #(.SETTLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Gate models: 0 const0, 1 const1, 2 xor3, 3 in1|in3 (0x5F), 4 lookup by hex name
  int         gmode = 0;
  logic [7:0] gtab  = 8'h00;
  int         gidx;

  always_comb begin
    gidx = 7 - int'(bus.stim);
    case (gmode)
      0:       bus.dut_out = 1'b0;
      1:       bus.dut_out = 1'b1;
      2:       bus.dut_out = bus.stim[2] ^ bus.stim[1] ^ bus.stim[0];
      3:       bus.dut_out = bus.stim[2] | bus.stim[0];
      default: bus.dut_out = gtab[gidx];
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full run; expected timing: cycle t after accept, rows of 5 cycles, done at t=41.
  task automatic run(input string tag, input logic [7:0] exp_code, input int poke_at);
    int done_cnt, done_t;
    logic stim_ok, busy_ok;
    logic [7:0] code_at_done;
    int exp_stim;
`ifdef TRUTH_TABLE_EXPECT_CHECK_EN
    logic [7:0] mism_at_done;
    logic match_at_done;
    mism_at_done = 8'hxx;
    match_at_done = 1'bx;
`endif
    done_cnt = 0; done_t = -1; stim_ok = 1'b1; busy_ok = 1'b1; code_at_done = 8'hxx;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      if (t <= 40)       exp_stim = (t - 1) / 5;
      else if (t == 41)  exp_stim = 7;
      else               exp_stim = 0;
      if (int'(bus.stim) != exp_stim) stim_ok = 1'b0;
      if (bus.busy !== (t <= 41)) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_t = t;
        code_at_done = bus.code;
`ifdef TRUTH_TABLE_EXPECT_CHECK_EN
        mism_at_done = bus.mismatch;
        match_at_done = bus.match;
`endif
      end
      bus.start = (t == poke_at);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, " done_cycle"}, done_t, 41);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " code"}, code_at_done, exp_code);
    check({tag, " code_held"}, bus.code, exp_code);
    check({tag, " stim_walk"}, stim_ok, 1);
    check({tag, " busy_window"}, busy_ok, 1);
`ifdef TRUTH_TABLE_EXPECT_CHECK_EN
    check({tag, " mismatch"}, mism_at_done, exp_code ^ bus.expected);
    check({tag, " match"}, match_at_done, exp_code == bus.expected);
`endif
  endtask

  typedef struct {
    int         mode;
    logic [7:0] tab;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic ok;
    vecs[0] = '{3, 8'h00, 8'h5F};
    vecs[1] = '{0, 8'h00, 8'h00};
    vecs[2] = '{1, 8'h00, 8'hFF};
    vecs[3] = '{2, 8'h00, 8'h69};
    vecs[4] = '{4, 8'hA6, 8'hA6};

    // Reset with random inputs
    bus.start = 1'($urandom);
    gmode = 1;
`ifdef TRUTH_TABLE_EXPECT_CHECK_EN
    bus.expected = 8'($urandom);
`endif
    repeat (3) @(negedge clk);
    check("rst stim", bus.stim, 0);
    check("rst code", bus.code, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.stim !== 3'd0 || bus.code !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) ok = 1'b0;
    end
    check("idle_hold", ok, 1);

    // Table-driven runs
    foreach (vecs[i]) begin
      gmode = vecs[i].mode;
      gtab  = vecs[i].tab;
`ifdef TRUTH_TABLE_EXPECT_CHECK_EN
      bus.expected = vecs[i].exp;
`endif
      run($sformatf("vec%0d", i), vecs[i].exp, 0);
    end

    // Start pulse mid-run is ignored
    gmode = 3;
    run("start_mid_run", 8'h5F, 10);

    // Reset at cycle 20 of a run
    gmode = 1;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort stim", bus.stim, 0);
    check("abort code", bus.code, 0);
    check("abort busy", bus.busy, 0);
    @(negedge clk); rst_n = 1'b1;
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.code !== 8'h00) ok = 1'b0;
    end
    check("abort no_done", ok, 1);
    run("after_abort", 8'hFF, 0);

    // Random gates: the probe must read back each gate's own hex name
    gmode = 4;
    for (int r = 0; r < 6; r++) begin
      gtab = 8'($urandom);
`ifdef TRUTH_TABLE_EXPECT_CHECK_EN
      bus.expected = (r % 2 == 0) ? gtab : 8'($urandom);
`endif
      run($sformatf("rand%0d_%02h", r, gtab), gtab, 0);
    end

`ifdef TRUTH_TABLE_EXPECT_CHECK_EN
    gmode = 4; gtab = 8'h5E;
    bus.expected = 8'h5F;
    run("expect_miss", 8'h5E, 0);
    check("expect_miss mismatch01", bus.mismatch, 8'h01);
    check("expect_miss match0", bus.match, 0);
    bus.expected = 8'h5E;
    run("expect_hit", 8'h5E, 0);
    check("expect_hit match1", bus.match, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
